// File: rtl/dlf_pkg.sv
// Shared types and helpers for the loop-filter back end (FCW/NCO/DCO stage).
//   CTRL_W_DEF : control word width delivered by the loop filter
//   ACC_W_DEF  : phase accumulator / FCW width
//   ctrl_t     : control word type
//   fcw_t      : frequency control word type
//   sat_add_fcw: center + (ctrl << shift), clamped to the FCW range
package dlf_pkg;

    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 16;

    typedef logic [CTRL_W_DEF-1:0] ctrl_t;
    typedef logic [ACC_W_DEF-1:0]  fcw_t;

    // The sum is formed one bit wider than the FCW so that a carry out is
    // visible and can be turned into a clamp instead of a wrap.
    function automatic fcw_t sat_add_fcw(input fcw_t center, input ctrl_t ctrl,
                                         input int unsigned shift);
        logic [ACC_W_DEF:0] sum;
        sum = {1'b0, center} + ((ACC_W_DEF + 1)'(ctrl) << shift);
        return sum[ACC_W_DEF] ? '1 : sum[ACC_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/dlf_lock_detect.sv
// Lock detector: counts consecutive accepted control samples whose distance
// from the previously captured sample stays within LOCK_TOL.
//   clk, rst : system clock, asynchronous active-high reset
//   sample   : newly presented control word
//   valid    : sample is accepted this cycle
//   prev     : control word captured before this sample
//   locked   : LOCK_CNT consecutive stable samples seen
module dlf_lock_detect
    import dlf_pkg::*;
#(
    parameter int unsigned CTRL_W   = CTRL_W_DEF,
    parameter int unsigned LOCK_TOL = 4,
    parameter int unsigned LOCK_CNT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] sample,
    input  logic              valid,
    input  logic [CTRL_W-1:0] prev,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

    logic [CTRL_W:0]  delta;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] stable_nxt;

    // One extra bit so the subtraction never wraps.
    always_comb begin
        delta      = '0;
        stable_nxt = '0;
        if (sample >= prev)
            delta = {1'b0, sample} - {1'b0, prev};
        else
            delta = {1'b0, prev} - {1'b0, sample};
        if (delta <= (CTRL_W + 1)'(LOCK_TOL)) begin
            if (stable_cnt == CNT_W'(LOCK_CNT))
                stable_nxt = stable_cnt;
            else
                stable_nxt = stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            locked     <= 1'b0;
        end else if (valid) begin
            stable_cnt <= stable_nxt;
            locked     <= (stable_nxt == CNT_W'(LOCK_CNT));
        end
    end

endmodule

// File: rtl/dlf_dco_nco.sv
// Loop-filter back end: turns the filter control word into an FCW, runs the
// phase accumulator, derives the DCO square wave and the divided feedback
// pulse, and flags lock when the control word settles.
//   clk, rst   : system clock, asynchronous active-high reset
//   ctrl_in    : loop filter output (unsigned)
//   ctrl_valid : ctrl_in carries a new sample
//   freeze     : open-loop hold of FCW and lock state; samples are dropped
//   fcw_out    : registered FCW
//   phase_out  : phase accumulator
//   dco_out    : accumulator MSB
//   fb_pulse   : one-cycle pulse every DIV_N-th DCO rising edge
//   locked     : lock indicator
module dlf_dco_nco
    import dlf_pkg::*;
#(
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned CTRL_W     = CTRL_W_DEF,
    parameter int unsigned CENTER_FCW = 4096,
    parameter int unsigned GAIN_SHIFT = 2,
    parameter int unsigned DIV_N      = 8,
    parameter int unsigned LOCK_TOL   = 4,
    parameter int unsigned LOCK_CNT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              ctrl_valid,
    input  logic              freeze,
    output logic [ACC_W-1:0]  fcw_out,
    output logic [ACC_W-1:0]  phase_out,
    output logic              dco_out,
    output logic              fb_pulse,
    output logic              locked
);

    localparam int unsigned DIV_W = $clog2(DIV_N);

    logic [CTRL_W-1:0] ctrl_q;
    logic [ACC_W-1:0]  fcw_d;
    logic              accept;
    logic              dco_prev;
    logic              dco_rise;
    logic [DIV_W-1:0]  div_cnt;

    // freeze wins: a sample offered during freeze is simply lost.
    assign accept   = ctrl_valid && !freeze;
    assign fcw_d    = ACC_W'(sat_add_fcw(fcw_t'(CENTER_FCW), ctrl_t'(ctrl_q), GAIN_SHIFT));
    assign dco_out  = phase_out[ACC_W-1];
    assign dco_rise = dco_out && !dco_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (accept) begin
            ctrl_q <= ctrl_in;
        end
    end

    // Registered every cycle; since ctrl_q is held during freeze the FCW holds too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_out <= ACC_W'(CENTER_FCW);
        end else begin
            fcw_out <= fcw_d;
        end
    end

    // Free-running accumulator, wraps naturally; freeze does not stop it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_out <= '0;
        end else begin
            phase_out <= phase_out + fcw_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dco_prev <= 1'b0;
            div_cnt  <= '0;
            fb_pulse <= 1'b0;
        end else begin
            dco_prev <= dco_out;
            fb_pulse <= 1'b0;
            if (dco_rise) begin
                if (div_cnt == DIV_W'(DIV_N - 1)) begin
                    div_cnt  <= '0;
                    fb_pulse <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    dlf_lock_detect #(
        .CTRL_W   (CTRL_W),
        .LOCK_TOL (LOCK_TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock (
        .clk    (clk),
        .rst    (rst),
        .sample (ctrl_in),
        .valid  (accept),
        .prev   (ctrl_q),
        .locked (locked)
    );

endmodule

// File: tb/tb_dlf_dco_nco.sv
// Scoreboard bench for dlf_dco_nco: two instances (default centre and a
// near-full-scale centre that saturates) share one stimulus stream.
module tb_dlf_dco_nco;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ctrl_in = '0;
    logic       ctrl_valid = 1'b0;
    logic       freeze = 1'b0;

    logic [15:0] fcw0, phase0, fcw1, phase1;
    logic        dco0, pulse0, lock0, dco1, pulse1, lock1;

    always #5 clk = ~clk;

    dlf_dco_nco dut (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
        .freeze(freeze), .fcw_out(fcw0), .phase_out(phase0), .dco_out(dco0),
        .fb_pulse(pulse0), .locked(lock0)
    );

    dlf_dco_nco #(.CENTER_FCW(65000)) dut_sat (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
        .freeze(freeze), .fcw_out(fcw1), .phase_out(phase1), .dco_out(dco1),
        .fb_pulse(pulse1), .locked(lock1)
    );

    typedef struct packed {
        logic [15:0] fcw;
        logic [15:0] phase;
        logic        dco;
        logic        pulse;
        logic        locked;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural reference state
    int m_ctrl, m_stable;
    bit m_locked;
    int m_fcw[2], m_phase[2], m_edges[2];
    bit m_dco_prev[2], m_pulse[2];

    function automatic int center(input int i);
        return (i == 0) ? 4096 : 65000;
    endfunction

    task automatic model_reset();
        m_ctrl   = 0;
        m_stable = 0;
        m_locked = 0;
        for (int i = 0; i < 2; i++) begin
            m_fcw[i]      = center(i);
            m_phase[i]    = 0;
            m_edges[i]    = 0;
            m_dco_prev[i] = 0;
            m_pulse[i]    = 0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.fcw    = 16'(m_fcw[i]);
            e.phase  = 16'(m_phase[i]);
            e.dco    = (m_phase[i] >= 32768);
            e.pulse  = m_pulse[i];
            e.locked = m_locked;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Advance the reference by one clock using the inputs seen at that edge.
    task automatic model_step();
        int d, f;
        bit dco, rise;
        for (int i = 0; i < 2; i++) begin
            dco  = (m_phase[i] >= 32768);
            rise = dco && !m_dco_prev[i];
            m_dco_prev[i] = dco;
            if (rise) m_edges[i]++;
            m_pulse[i] = rise && (m_edges[i] % 8 == 0);
            m_phase[i] = (m_phase[i] + m_fcw[i]) % 65536;
            f = center(i) + m_ctrl * 4;
            m_fcw[i] = (f > 65535) ? 65535 : f;
        end
        if (ctrl_valid && !freeze) begin
            d = int'(ctrl_in) - m_ctrl;
            if (d < 0) d = -d;
            if (d <= 4) m_stable = (m_stable >= 16) ? 16 : m_stable + 1;
            else        m_stable = 0;
            m_locked = (m_stable == 16);
            m_ctrl   = int'(ctrl_in);
        end
    endtask

    task automatic cycle(input bit cv, input int ci, input bit fz);
        ctrl_valid = cv;
        ctrl_in    = 8'(ci);
        freeze     = fz;
        @(posedge clk);
        #1;
        model_step();
        push_exp();
    endtask

    // Asynchronous reset asserted and released away from the clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        push_exp();
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: the DUT presents a new output word every cycle.
    always @(negedge clk) begin
        exp_t e, a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {fcw0, phase0, dco0, pulse0, lock0};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL nco_ctr t=%0t got fcw=%0d ph=%0d dco=%0b fb=%0b lk=%0b want fcw=%0d ph=%0d dco=%0b fb=%0b lk=%0b",
                         $time, a.fcw, a.phase, a.dco, a.pulse, a.locked,
                         e.fcw, e.phase, e.dco, e.pulse, e.locked);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {fcw1, phase1, dco1, pulse1, lock1};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL nco_sat t=%0t got fcw=%0d ph=%0d dco=%0b fb=%0b lk=%0b want fcw=%0d ph=%0d dco=%0b fb=%0b lk=%0b",
                         $time, a.fcw, a.phase, a.dco, a.pulse, a.locked,
                         e.fcw, e.phase, e.dco, e.pulse, e.locked);
            end
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int last, ci;
        bit done;
        model_reset();
        push_exp();
        do_reset();

        // Idle after reset: centre FCW, DCO period and first feedback pulses
        repeat (300) cycle(0, 0, 0);

        // Single full-scale sample, then idle (saturates in the second instance)
        cycle(1, 255, 0);
        repeat (40) cycle(0, 0, 0);

        // Freeze drops a sample and holds FCW/lock state
        cycle(1, 10, 0);
        repeat (3) cycle(0, 0, 0);
        repeat (6) cycle(1, 200, 1);
        repeat (10) cycle(0, 0, 0);

        // Lock build-up and loss
        for (int k = 0; k < 17; k++) begin
            cycle(1, (k % 2 == 0) ? 100 : 103, 0);
            cycle(0, 0, 0);
        end
        cycle(1, 110, 0);
        repeat (4) cycle(0, 0, 0);

        // Randomised traffic, mostly small steps so lock toggles
        last = 110;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) ci = $urandom_range(0, 255);
            else ci = last + $urandom_range(0, 10) - 5;
            if (ci < 0) ci = 0;
            if (ci > 255) ci = 255;
            if ($urandom_range(0, 1) == 1 && $urandom_range(0, 7) != 0) last = ci;
            cycle(bit'($urandom_range(0, 1)), ci, ($urandom_range(0, 7) == 0));
        end

        // Lock up, then reset mid-run with the divider part-way through
        repeat (20) cycle(1, 50, 0);
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (m_locked && (m_edges[0] % 8 == 5)) done = 1;
            else cycle(1, 50, 0);
        end
        if (!done) begin
            n_err++;
            $display("FAIL div_cnt_wait got no lock/div_cnt=5 within 400 cycles want reached");
        end
        do_reset();
        repeat (300) cycle(0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
